// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: packs camera byte pairs into RGB565 pixels and writes them to a FIFO, frame by frame
// Ports:
//   clk, reset (async active-low)    camera pixel clock and reset
//   frame_en                          level enable; low returns to idle
//   cam_vsync, cam_href, cam_data     camera frame sync, line valid and byte bus
//   wrfull_cam                        FIFO full; a pixel meeting it is lost and the frame is dropped
//   wrreq_cam, wrdata_cam             registered FIFO write strobe and RGB565 pixel
//   frame_done                        one-cycle pulse after the last line of a frame
//   overflow                          sticky pixel-lost flag
//   line_cnt                          current line index within the frame
module cam_pixel_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        wrfull_cam,
  output logic        wrreq_cam,
  output logic [15:0] wrdata_cam,
  output logic        frame_done,
  output logic        overflow,
  output logic [9:0]  line_cnt
);
  typedef enum logic [2:0] {s_idle, s_wait_vs, s_wait_start, s_frame, s_drop} state_t;
  state_t state, state_nx;
  logic phase, href_d;
  logic [7:0] hi_byte;
  logic [15:0] pix_cnt;
  logic in_frame, href_fall, pix_ok, do_write, do_drop, do_done;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= s_idle;
    else state <= state_nx;
  // vsync during a frame aborts it, so every capture event is qualified by vsync low
  always_comb begin
    in_frame = frame_en && state == s_frame && !cam_vsync;
    href_fall = in_frame && href_d && !cam_href;
    pix_ok = in_frame && cam_href && phase && pix_cnt < 16'(H_PIXELS);
    do_write = pix_ok && !wrfull_cam;
    do_drop = pix_ok && wrfull_cam;
    do_done = href_fall && line_cnt == 10'(V_LINES - 1);
  end
  always_comb begin
    state_nx = state;
    if (!frame_en) state_nx = s_idle;
    else
      case (state)
        s_idle:       state_nx = s_wait_vs;
        s_wait_vs:    state_nx = cam_vsync ? s_wait_start : s_wait_vs;
        s_wait_start: state_nx = cam_vsync ? s_wait_start : s_frame;
        s_frame:      state_nx = cam_vsync ? s_wait_start : do_drop ? s_drop : do_done ? s_wait_vs : s_frame;
        s_drop:       state_nx = cam_vsync ? s_wait_start : s_drop;
        default:      state_nx = s_idle;
      endcase
  end
  // line/pixel/phase counters only live inside an uninterrupted frame; any entry or exit clears them
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      href_d <= 1'b0;
      phase <= 1'b0;
      hi_byte <= 8'd0;
      pix_cnt <= 16'd0;
      line_cnt <= 10'd0;
      wrreq_cam <= 1'b0;
      wrdata_cam <= 16'd0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      href_d <= cam_href;
      wrreq_cam <= do_write;
      frame_done <= do_done;
      if (do_write) wrdata_cam <= {hi_byte, cam_data};
      if (do_drop) overflow <= 1'b1;
      if (state != s_frame || state_nx != s_frame) begin
        line_cnt <= 10'd0;
        pix_cnt <= 16'd0;
        phase <= 1'b0;
      end else if (href_fall) begin
        line_cnt <= line_cnt + 10'd1;
        pix_cnt <= 16'd0;
        phase <= 1'b0;
      end else if (in_frame && cam_href) begin
        phase <= !phase;
        if (!phase) hi_byte <= cam_data;
        if (pix_ok) pix_cnt <= pix_cnt + 16'd1;
      end
    end
endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb_cam_pixel_capture: directed table and sequence checks of cam_pixel_capture with 2x2 frames
module tb_cam_pixel_capture;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_en = 1'b0;
  logic cam_vsync = 1'b0;
  logic cam_href = 1'b0;
  logic [7:0] cam_data = 8'd0;
  logic wrfull_cam = 1'b0;
  logic wrreq_cam;
  logic [15:0] wrdata_cam;
  logic frame_done;
  logic overflow;
  logic [9:0] line_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int nwr = 0;
  int ndone = 0;
  int w0, d0;
  cam_pixel_capture #(.H_PIXELS(2), .V_LINES(2)) dut (
    .clk(clk), .reset(reset), .frame_en(frame_en), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .wrfull_cam(wrfull_cam),
    .wrreq_cam(wrreq_cam), .wrdata_cam(wrdata_cam), .frame_done(frame_done),
    .overflow(overflow), .line_cnt(line_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (wrreq_cam) nwr++;
    if (frame_done) ndone++;
  end
  typedef struct {
    logic vs, href;
    logic [7:0] d;
    logic full;
    logic wr;
    logic [15:0] wd;
    logic done;
    logic [9:0] line;
  } vec_t;
  vec_t tbl[31];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic en, input logic vs, input logic h, input logic [7:0] d, input logic f);
    frame_en = en;
    cam_vsync = vs;
    cam_href = h;
    cam_data = d;
    wrfull_cam = f;
    @(posedge clk);
    #1;
  endtask
  task automatic send_line(input logic [7:0] base, input int nb, input int full_idx);
    for (int i = 0; i < nb; i++) cyc(1, 0, 1, base + 8'(i), i == full_idx);
    cyc(1, 0, 0, 8'd0, 0);
  endtask
  task automatic frame_start();
    cyc(1, 0, 0, 8'd0, 0);
    cyc(1, 1, 0, 8'd0, 0);
    cyc(1, 0, 0, 8'd0, 0);
  endtask
  initial begin
    tbl[0]  = '{0, 0, 8'h00, 0, 0, 16'h0000, 0, 10'd0};
    tbl[1]  = '{1, 0, 8'h00, 0, 0, 16'h0000, 0, 10'd0};
    tbl[2]  = '{1, 0, 8'h00, 0, 0, 16'h0000, 0, 10'd0};
    tbl[3]  = '{0, 0, 8'h00, 0, 0, 16'h0000, 0, 10'd0};
    tbl[4]  = '{0, 1, 8'hA1, 0, 0, 16'h0000, 0, 10'd0};
    tbl[5]  = '{0, 1, 8'hB2, 0, 1, 16'hA1B2, 0, 10'd0};
    tbl[6]  = '{0, 1, 8'hC3, 0, 0, 16'hA1B2, 0, 10'd0};
    tbl[7]  = '{0, 1, 8'hD4, 0, 1, 16'hC3D4, 0, 10'd0};
    tbl[8]  = '{0, 0, 8'h00, 0, 0, 16'hC3D4, 0, 10'd1};
    tbl[9]  = '{0, 1, 8'h11, 0, 0, 16'hC3D4, 0, 10'd1};
    tbl[10] = '{0, 1, 8'h22, 0, 1, 16'h1122, 0, 10'd1};
    tbl[11] = '{0, 1, 8'h33, 0, 0, 16'h1122, 0, 10'd1};
    tbl[12] = '{0, 1, 8'h44, 0, 1, 16'h3344, 0, 10'd1};
    tbl[13] = '{0, 0, 8'h00, 0, 0, 16'h3344, 1, 10'd0};
    tbl[14] = '{0, 0, 8'h00, 0, 0, 16'h3344, 0, 10'd0};
    tbl[15] = '{1, 0, 8'h00, 0, 0, 16'h3344, 0, 10'd0};
    tbl[16] = '{0, 0, 8'h00, 0, 0, 16'h3344, 0, 10'd0};
    tbl[17] = '{0, 1, 8'h55, 0, 0, 16'h3344, 0, 10'd0};
    tbl[18] = '{0, 1, 8'h66, 0, 1, 16'h5566, 0, 10'd0};
    tbl[19] = '{0, 1, 8'h77, 0, 0, 16'h5566, 0, 10'd0};
    tbl[20] = '{0, 1, 8'h88, 0, 1, 16'h7788, 0, 10'd0};
    tbl[21] = '{0, 1, 8'h99, 0, 0, 16'h7788, 0, 10'd0};
    tbl[22] = '{0, 0, 8'h00, 0, 0, 16'h7788, 0, 10'd1};
    tbl[23] = '{0, 1, 8'hAA, 0, 0, 16'h7788, 0, 10'd1};
    tbl[24] = '{0, 1, 8'hBB, 0, 1, 16'hAABB, 0, 10'd1};
    tbl[25] = '{0, 1, 8'hCC, 0, 0, 16'hAABB, 0, 10'd1};
    tbl[26] = '{0, 1, 8'hDD, 0, 1, 16'hCCDD, 0, 10'd1};
    tbl[27] = '{0, 1, 8'hEE, 0, 0, 16'hCCDD, 0, 10'd1};
    tbl[28] = '{0, 1, 8'hFF, 0, 0, 16'hCCDD, 0, 10'd1};
    tbl[29] = '{0, 0, 8'h00, 0, 0, 16'hCCDD, 1, 10'd0};
    tbl[30] = '{0, 0, 8'h00, 0, 0, 16'hCCDD, 0, 10'd0};
    cyc(1, 1, 1, 8'h5A, 0);
    cyc(1, 0, 1, 8'hA5, 0);
    chk("rst_wrreq", wrreq_cam, 0);
    chk("rst_wrdata", wrdata_cam, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_line", line_cnt, 0);
    cyc(0, 0, 0, 8'd0, 0);
    reset = 1'b1;
    for (int i = 0; i < 31; i++) begin
      cyc(1, tbl[i].vs, tbl[i].href, tbl[i].d, tbl[i].full);
      chk($sformatf("vec%0d_wrreq", i), wrreq_cam, tbl[i].wr);
      chk($sformatf("vec%0d_wrdata", i), wrdata_cam, tbl[i].wd);
      chk($sformatf("vec%0d_done", i), frame_done, tbl[i].done);
      chk($sformatf("vec%0d_line", i), line_cnt, tbl[i].line);
      chk($sformatf("vec%0d_ovf", i), overflow, 0);
    end
    // FIFO full on the third pixel: frame dropped until the next vsync
    frame_start();
    w0 = nwr;
    d0 = ndone;
    send_line(8'h10, 4, -1);
    send_line(8'h20, 4, 1);
    chk("ovf_set", overflow, 1);
    chk("ovf_writes", nwr - w0, 2);
    send_line(8'h30, 4, -1);
    chk("ovf_drop_writes", nwr - w0, 2);
    frame_start();
    send_line(8'h40, 4, -1);
    send_line(8'h50, 4, -1);
    cyc(1, 0, 0, 8'd0, 0);
    chk("ovf_resync_writes", nwr - w0, 6);
    chk("ovf_resync_done", ndone - d0, 1);
    chk("ovf_sticky", overflow, 1);
    // vsync after line 0 aborts the frame
    d0 = ndone;
    frame_start();
    send_line(8'h60, 4, -1);
    chk("abort_line_before", line_cnt, 1);
    cyc(1, 1, 0, 8'd0, 0);
    chk("abort_line_after", line_cnt, 0);
    cyc(1, 1, 0, 8'd0, 0);
    cyc(1, 0, 0, 8'd0, 0);
    chk("abort_no_done", ndone - d0, 0);
    w0 = nwr;
    send_line(8'h70, 4, -1);
    send_line(8'h80, 4, -1);
    cyc(1, 0, 0, 8'd0, 0);
    chk("abort_restart_writes", nwr - w0, 4);
    chk("abort_restart_data", wrdata_cam, 16'h8283);
    chk("abort_restart_done", ndone - d0, 1);
    // falling href together with vsync on the last line is an abort
    d0 = ndone;
    frame_start();
    send_line(8'h90, 4, -1);
    cyc(1, 0, 1, 8'h94, 0);
    cyc(1, 0, 1, 8'h95, 0);
    cyc(1, 1, 0, 8'd0, 0);
    cyc(1, 0, 0, 8'd0, 0);
    chk("simul_no_done", ndone - d0, 0);
    chk("simul_line", line_cnt, 0);
    send_line(8'hA0, 4, -1);
    send_line(8'hB0, 4, -1);
    cyc(1, 0, 0, 8'd0, 0);
    chk("simul_restart_done", ndone - d0, 1);
    // frame_en dropped between the two bytes of a pixel
    frame_start();
    w0 = nwr;
    cyc(1, 0, 1, 8'hC1, 0);
    cyc(0, 0, 1, 8'hC2, 0);
    chk("en_off_wrreq", wrreq_cam, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 8'(i), 0);
      chk($sformatf("en_off_wrreq%0d", i), wrreq_cam, 0);
    end
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 8'(i), 0);
    cyc(1, 0, 0, 8'd0, 0);
    chk("en_off_writes", nwr - w0, 0);
    chk("en_off_ovf_kept", overflow, 1);
    // asynchronous reset mid-line
    frame_start();
    send_line(8'hD0, 4, -1);
    cyc(1, 0, 1, 8'hE1, 0);
    cyc(1, 0, 1, 8'hE2, 0);
    chk("pre_rst_wrreq", wrreq_cam, 1);
    chk("pre_rst_line", line_cnt, 1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_wrreq", wrreq_cam, 0);
    chk("async_rst_wrdata", wrdata_cam, 0);
    chk("async_rst_done", frame_done, 0);
    chk("async_rst_ovf", overflow, 0);
    chk("async_rst_line", line_cnt, 0);
    cyc(1, 0, 1, 8'hE3, 0);
    cyc(1, 0, 1, 8'hE4, 0);
    reset = 1'b1;
    w0 = nwr;
    d0 = ndone;
    for (int i = 0; i < 6; i++) cyc(1, 0, (i != 4), 8'hF0 + 8'(i), 0);
    cyc(1, 0, 0, 8'd0, 0);
    chk("post_rst_no_write", nwr - w0, 0);
    frame_start();
    send_line(8'h31, 4, -1);
    send_line(8'h41, 4, -1);
    cyc(1, 0, 0, 8'd0, 0);
    chk("post_rst_writes", nwr - w0, 4);
    chk("post_rst_done", ndone - d0, 1);
    chk("post_rst_data", wrdata_cam, 16'h4344);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cam_pixel_capture.md
CAM_PIXEL_CAPTURE -- requirements
Module: cam_pixel_capture

Interface
REQ-001 SHALL have parameter H_PIXELS, default 640, meaning 16-bit pixels per active line.
REQ-002 SHALL have parameter V_LINES, default 480, meaning active lines per frame.
REQ-003 SHALL have port clk, input, 1, camera pixel clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port frame_en, input, 1, level capture enable from the top-level controller.
REQ-006 SHALL have port cam_vsync, input, 1, active-high frame sync.
REQ-007 SHALL have port cam_href, input, 1, active-high line valid.
REQ-008 SHALL have port cam_data, input, 8, camera byte bus.
REQ-009 SHALL have port wrfull_cam, input, 1, camera FIFO write-side full.
REQ-010 SHALL have port wrreq_cam, output, 1, active-high FIFO write request.
REQ-011 SHALL have port wrdata_cam, output, 16, RGB565 pixel to the FIFO.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse when a complete frame has been written.
REQ-013 SHALL have port overflow, output, 1, sticky flag for a pixel lost to FIFO full.
REQ-014 SHALL have port line_cnt, output, 10, current line index (0 to V_LINES-1).

Function
REQ-015 SHALL implement states s_idle, s_wait_vs, s_wait_start, s_frame and s_drop.
REQ-016 s_idle SHALL go to s_wait_vs when frame_en=1; it SHALL remain in s_idle otherwise.
REQ-017 s_wait_vs SHALL go to s_wait_start on a sampled cam_vsync=1.
REQ-018 s_wait_start SHALL go to s_frame on the first sampled cam_vsync=0, with line_cnt, pixel count and byte phase cleared.
REQ-019 In s_frame, each sampled cam_href=1 byte SHALL toggle the byte phase; the first byte is wrdata_cam[15:8] and the second is wrdata_cam[7:0].
REQ-020 wrreq_cam SHALL be registered: when the second byte is sampled at edge N with wrfull_cam=0, wrreq_cam=1 for exactly the cycle after edge N, with wrdata_cam valid in that same cycle.
REQ-021 wrdata_cam SHALL hold its last value while wrreq_cam=0.
REQ-022 wrreq_cam SHALL never be asserted outside s_frame.
REQ-023 If wrfull_cam=1 when the second byte is sampled, the pixel SHALL be discarded, overflow set to 1, and the state SHALL go to s_drop.
REQ-024 s_drop SHALL write nothing and SHALL go to s_wait_start on cam_vsync=1 (resynchronise at the next frame).
REQ-025 A falling cam_href (previous sample 1, current 0) SHALL increment line_cnt, clear the pixel count, and clear the byte phase (a dangling odd byte is discarded).
REQ-026 Pixels beyond H_PIXELS in a line SHALL be discarded without a write.
REQ-027 When line_cnt would reach V_LINES, frame_done SHALL pulse for 1 cycle, line_cnt SHALL return to 0, and the state SHALL go to s_wait_vs.
REQ-028 cam_vsync=1 in s_frame before V_LINES lines have completed SHALL abort the frame: no frame_done pulse, go to s_wait_start.
REQ-029 frame_en=0 SHALL return the FSM to s_idle at the next edge from any state, with any partial pixel discarded.
REQ-030 frame_en=0 SHALL NOT clear overflow.
REQ-031 Simultaneous falling href and vsync=1 SHALL be treated as an abort (REQ-028 takes priority over REQ-027).
REQ-032 Unused or illegal state encodings SHALL recover to s_idle.

Reset
REQ-033 reset=0 SHALL immediately force: state s_idle, wrreq_cam=0, wrdata_cam=0, frame_done=0, overflow=0, line_cnt=0, byte phase 0.
REQ-034 Reset asserted mid-frame SHALL abort without a partial write.
REQ-035 After reset release, capture SHALL begin only at a full vsync high-then-low sequence.

Verification
REQ-036 Bench SHALL run: frame_en=1, vsync pulse, 2 lines of 4 bytes each (H_PIXELS=2, V_LINES=2) -> 4 writes, first wrdata_cam=0xA1B2 from bytes A1,B2, then a 1-cycle frame_done.
REQ-037 Bench SHALL run: wrfull_cam=1 during the 3rd pixel -> 2 writes only, overflow=1, no further writes until the next vsync, overflow still 1 after that frame.
REQ-038 Bench SHALL run: vsync=1 after line 0 of a 2-line frame -> no frame_done, line_cnt=0, capture restarts cleanly on the next frame.
REQ-039 Bench SHALL run: a line of 5 bytes -> 2 writes, the odd byte dropped, the next line starts on the high byte.
REQ-040 Bench SHALL run: reset=0 asynchronously mid-line -> all outputs 0 within the same cycle, no write after release until a new vsync sequence.
REQ-041 Bench SHALL run: frame_en deasserted mid-frame -> s_idle on the next edge, wrreq_cam=0 thereafter.
